mem_access_unit: RTL and testbench

//  Memory-stage consumer of the EX/MEM control/data pipeline register outputs (RV32IF pipeline).

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM store/load control into a
// request/grant data-memory transaction, stalls the pipeline until the
// access completes, and returns extended load data to MEM/WB.
//
// state | meaning
// IDLE  | waiting for a memory op; alignment checked here
// REQ   | dmem_req held, waiting for dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// DONE  | one-cycle completion; result pulses valid, pipeline advances
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        LoadValidM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_f3;
    logic [1:0]    op_lo;

    logic          mem_op;
    logic          aligned;
    logic [3:0]    wstrb_c;
    logic [31:0]   wdata_c;
    logic [31:0]   load_ext;
    logic [31:0]   byte_sh;
    logic [31:0]   half_sh;

    // RegWriteM only matters to writeback; the bus never looks at it
    logic unused_regwrite;
    assign unused_regwrite = RegWriteM;

    assign mem_op = MemWriteM | (ResultSrcM == 2'b01);
    assign StallM = ((state == S_IDLE) & mem_op) | (state == S_REQ) | (state == S_WAIT);

    // Alignment check and store lane placement for the incoming op
    always_comb begin
        aligned = 1'b1;
        wstrb_c = 4'b1111;
        wdata_c = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                aligned = 1'b1;
                wstrb_c = 4'b0001 << ALUResultM[1:0];
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                aligned = ~ALUResultM[0];
                wstrb_c = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
                aligned = (ALUResultM[1:0] == 2'b00);
                wstrb_c = 4'b1111;
                wdata_c = WriteDataM;
            end
        endcase
    end

    // Load extraction uses the size/offset latched at issue
    always_comb begin
        byte_sh  = dmem_rdata >> {op_lo, 3'b000};
        half_sh  = dmem_rdata >> {op_lo[1], 4'b0000};
        load_ext = dmem_rdata;
        case (op_f3)
            3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_ext = {24'd0, byte_sh[7:0]};
            3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_ext = {16'd0, half_sh[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Access sequencer, bus outputs, timeout counter and result pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_f3      <= 3'b000;
            op_lo      <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
            ReadDataM  <= 32'd0;
            LoadValidM <= 1'b0;
            MisalignM  <= 1'b0;
            BusErrM    <= 1'b0;
        end else begin
            LoadValidM <= 1'b0;
            MisalignM  <= 1'b0;
            BusErrM    <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (mem_op) begin
                        if (aligned) begin
                            state      <= S_REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= MemWriteM;
                            dmem_addr  <= {ALUResultM[31:2], 2'b00};
                            dmem_wstrb <= MemWriteM ? wstrb_c : 4'd0;
                            dmem_wdata <= MemWriteM ? wdata_c : 32'd0;
                            op_f3      <= funct3M;
                            op_lo      <= ALUResultM[1:0];
                        end else begin
                            state     <= S_DONE;
                            MisalignM <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt || (cnt == CNT_LAST)) begin
                        // the bus is released whether granted or timed out
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= 32'd0;
                        dmem_wdata <= 32'd0;
                        dmem_wstrb <= 4'd0;
                        cnt        <= '0;
                        if (!dmem_gnt) begin
                            BusErrM <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state <= dmem_we ? S_DONE : S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        ReadDataM  <= load_ext;
                        LoadValidM <= 1'b1;
                        state      <= S_DONE;
                        cnt        <= '0;
                    end else if (cnt == CNT_LAST) begin
                        ReadDataM <= 32'd0;
                        BusErrM   <= 1'b1;
                        state     <= S_DONE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues ops and pushes the
// expected bus transfer and result pulse, a bus responder emulates the memory,
// and a monitor pops and compares whenever the DUT presents something.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        LoadValidM, MisalignM, BusErrM;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .funct3M(funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .ReadDataM(ReadDataM), .LoadValidM(LoadValidM),
        .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } bus_t;
    typedef struct packed { logic [2:0] pulses; logic [31:0] data; } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    npass = 0, ntotal = 0;

    // reference model state (byte-level) and the emulated memory (word-level)
    logic [7:0]  ref_mem[0:31];
    logic [31:0] smem[0:7];
    logic [31:0] last_rd;

    int gnt_dly = 0, rv_dly = 0;
    bit no_rv = 0, inject_rv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int op_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % op_size(f3)) == 0;
    endfunction

    // push expectations, drive one op, return stall and request cycle counts
    task automatic do_op(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int stalls, output int reqs);
        int sz, lo, idx;
        bit granted, rvok;
        bus_t b;
        resp_t r;
        logic [31:0] v;
        logic [1:0] rs;
        sz = op_size(f3);
        lo = int'(a % 4);
        idx = int'(a - 32'h100);
        granted = (gnt_dly <= TIMEOUT - 1);
        rvok = !no_rv && (rv_dly <= TIMEOUT - 1);
        if (st || ld) begin
            if (!is_aligned(f3, a)) begin
                r.pulses = 3'b010; r.data = last_rd; resp_q.push_back(r);
            end else begin
                b.we = st; b.addr = {a[31:2], 2'b00}; b.wstrb = 4'd0; b.wdata = 32'd0;
                if (st)
                    for (int j = 0; j < 4; j++) begin
                        b.wdata[8*j +: 8] = d[8*(j % sz) +: 8];
                        if (j >= lo && j < lo + sz) b.wstrb[j] = 1'b1;
                    end
                if (granted) bus_q.push_back(b);
                if (!granted) begin
                    r.pulses = 3'b001; r.data = last_rd; resp_q.push_back(r);
                end else if (st) begin
                    for (int i = 0; i < sz; i++) ref_mem[idx + i] = d[8*i +: 8];
                end else if (!rvok) begin
                    last_rd = 32'd0;
                    r.pulses = 3'b001; r.data = 32'd0; resp_q.push_back(r);
                end else begin
                    v = 32'd0;
                    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[idx + i]) << (8 * i));
                    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                    last_rd = v;
                    r.pulses = 3'b100; r.data = v; resp_q.push_back(r);
                end
            end
        end
        @(negedge clk);
        rs = 2'($urandom_range(0, 2));
        if (rs == 2'b01) rs = 2'b11;
        MemWriteM = st; ResultSrcM = ld ? 2'b01 : rs; funct3M = f3;
        ALUResultM = a; WriteDataM = d; RegWriteM = 1'($urandom);
        #1;
        stalls = 0; reqs = 0;
        for (int k = 0; k < 200; k++) begin
            if (!StallM) break;
            stalls++;
            if (dmem_req) reqs++;
            @(negedge clk); #1;
        end
        check("stall_released", {31'd0, StallM}, 32'd0);
        MemWriteM = 1'b0; ResultSrcM = 2'b00;
    endtask

    // bus responder: grant after gnt_dly cycles of request, read data rv_dly cycles later
    int   gcnt = 0, rcnt = 0, rd_idx = 0;
    bit   rd_pend = 0;
    initial begin
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (reset) begin
                rd_pend = 0; gcnt = 0;
            end else begin
                if (rd_pend) begin
                    if (rcnt == 0) begin
                        rd_pend = 0;
                        if (!no_rv) begin dmem_rvalid = 1; dmem_rdata = smem[rd_idx]; end
                    end else rcnt--;
                end
                if (inject_rv) begin dmem_rvalid = 1; dmem_rdata = 32'hCAFE_0001; end
                if (dmem_req) begin
                    if (gcnt >= gnt_dly) begin
                        dmem_gnt = 1; gcnt = 0;
                        if (dmem_we) begin
                            for (int j = 0; j < 4; j++)
                                if (dmem_wstrb[j]) smem[int'((dmem_addr - 32'h100) >> 2)][8*j +: 8] = dmem_wdata[8*j +: 8];
                        end else begin
                            rd_pend = 1; rcnt = rv_dly; rd_idx = int'((dmem_addr - 32'h100) >> 2);
                        end
                    end else gcnt++;
                end else gcnt = 0;
            end
        end
    end

    // monitor: compare every accepted bus transfer and every result pulse
    initial begin
        bus_t b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (dmem_req && dmem_gnt) begin
                if (bus_q.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_bus_req: got addr %h expected no request", dmem_addr);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
                    check("bus_addr", dmem_addr, b.addr);
                    check("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, b.wstrb});
                    if (b.we) check("bus_wdata", dmem_wdata, b.wdata);
                end
            end
            if (LoadValidM || MisalignM || BusErrM) begin
                if (resp_q.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_pulse: got %b expected none", {LoadValidM, MisalignM, BusErrM});
                end else begin
                    r = resp_q.pop_front();
                    check("resp_pulses", {29'd0, LoadValidM, MisalignM, BusErrM}, {29'd0, r.pulses});
                    check("resp_data", ReadDataM, r.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s, rq, kind;
        bit st, ld;
        logic [2:0] f3;
        logic [31:0] a, d;
        int exp_s;
        reset = 1; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; funct3M = 0;
        ALUResultM = 0; WriteDataM = 0; last_rd = 0;
        for (int w = 0; w < 8; w++) begin
            smem[w] = $urandom;
            for (int j = 0; j < 4; j++) ref_mem[4*w + j] = smem[w][8*j +: 8];
        end
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
        reset = 0;

        do_op(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, s, rq);
        check("sw_stall", s, 2); check("sw_req_cycles", rq, 1);
        do_op(1, 0, 3'd0, 32'h103, 32'h0000005A, s, rq);
        check("sb_stall", s, 2);
        do_op(1, 0, 3'd1, 32'h102, 32'h00001234, s, rq);
        check("sh_stall", s, 2);
        do_op(1, 0, 3'd2, 32'h100, 32'h000080FF, s, rq);
        do_op(0, 1, 3'd0, 32'h101, 32'd0, s, rq);
        check("lb_stall", s, 3); check("lb_value", ReadDataM, 32'hFFFF_FF80);
        do_op(0, 1, 3'd4, 32'h101, 32'd0, s, rq);
        check("lbu_value", ReadDataM, 32'h0000_0080);
        do_op(1, 0, 3'd2, 32'h100, 32'h80010000, s, rq);
        do_op(0, 1, 3'd1, 32'h102, 32'd0, s, rq);
        check("lh_value", ReadDataM, 32'hFFFF_8001);
        do_op(0, 1, 3'd2, 32'h102, 32'd0, s, rq);
        check("mis_stall", s, 1); check("mis_req_cycles", rq, 0);

        gnt_dly = 3; no_rv = 1;
        do_op(0, 1, 3'd2, 32'h104, 32'd0, s, rq);
        check("wait_timeout_stall", s, 21); check("wait_timeout_data", ReadDataM, 32'd0);
        gnt_dly = 0; no_rv = 0;
        do_op(0, 1, 3'd2, 32'h108, 32'd0, s, rq);
        gnt_dly = 99;
        do_op(0, 1, 3'd2, 32'h10C, 32'd0, s, rq);
        check("req_timeout_stall", s, 17); check("req_timeout_req_cycles", rq, 16);
        gnt_dly = 0;

        // reset while a load sits in WAIT
        no_rv = 1; rv_dly = 0;
        bus_q.push_back('{we: 1'b0, addr: 32'h104, wstrb: 4'd0, wdata: 32'd0});
        @(negedge clk);
        MemWriteM = 0; ResultSrcM = 2'b01; funct3M = 3'd2; ALUResultM = 32'h104;
        repeat (2) @(negedge clk);
        #1;
        check("inwait_stall", {31'd0, StallM}, 32'd1);
        reset = 1; ResultSrcM = 2'b00;
        #1;
        check("rst_mid_outs", {26'd0, dmem_req, dmem_we, dmem_wstrb}, 32'd0);
        check("rst_mid_addr", dmem_addr | dmem_wdata, 32'd0);
        check("rst_mid_rdata", ReadDataM, 32'd0);
        check("rst_mid_pulses_stall", {28'd0, LoadValidM, MisalignM, BusErrM, StallM}, 32'd0);
        last_rd = 32'd0;
        @(negedge clk); reset = 0; no_rv = 0; inject_rv = 1;
        repeat (2) @(negedge clk);
        inject_rv = 0;
        repeat (3) @(negedge clk);
        check("post_rst_rdata", ReadDataM, 32'd0);
        check("post_rst_stall", {31'd0, StallM}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            st = (kind == 0) || (kind == 2);
            ld = (kind == 1) || (kind == 2);
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a = 32'h100 + 32'($urandom_range(0, 31));
            d = $urandom;
            gnt_dly = $urandom_range(0, 3);
            rv_dly = $urandom_range(0, 3);
            do_op(st, ld, f3, a, d, s, rq);
            if (!(st || ld)) exp_s = 0;
            else if (!is_aligned(f3, a)) exp_s = 1;
            else exp_s = 2 + gnt_dly + (st ? 0 : rv_dly + 1);
            check("rand_stall", s, exp_s);
        end

        repeat (5) @(negedge clk);
        check("bus_q_drained", bus_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
